// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stall, multi-cycle multiply
// hold in EX, and branch flush. Control outputs are combinational; stall_cnt is registered.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 3,
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_is_mult,
  input  logic                  mem_branch_tkn,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
  output logic                  mult_busy,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int MCNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MULT_CYCLES - 1);
  localparam logic MULT_STALLS = (MULT_CYCLES > 1);

  typedef enum logic {
    RUN  = 1'b0,
    MULT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [MCNT_W-1:0] mcnt;
  logic [MCNT_W-1:0] mcnt_nxt;
  logic              load_use;
  logic              mult_stall;
  logic              stall;

  // Hazard detection. Register 0 is hardwired, so a load targeting it never stalls.
  always_comb begin
    load_use = ex_memread && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    mult_stall = ((state == RUN) && ex_is_mult && MULT_STALLS) ||
                 ((state == MULT) && (mcnt < MCNT_LAST));
  end

  // Priority: rst > branch flush > multiply > load-use.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mult_busy     = 1'b0;
    stall         = 1'b0;
    state_nxt     = state;
    mcnt_nxt      = mcnt;
    if (rst) begin
      state_nxt = RUN;
      mcnt_nxt  = '0;
    end else if (mem_branch_tkn) begin
      // Flushing also kills any multiply currently held in EX.
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      state_nxt     = RUN;
      mcnt_nxt      = '0;
    end else if (mult_stall) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
      mult_busy     = 1'b1;
      stall         = 1'b1;
      state_nxt     = MULT;
      mcnt_nxt      = (state == RUN) ? MCNT_W'(1) : mcnt + MCNT_W'(1);
    end else if (state == MULT) begin
      // Final multiply cycle: the result advances and the pipeline runs freely.
      state_nxt = RUN;
      mcnt_nxt  = '0;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      stall        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  // Saturating stall counter; branch flush cycles are not stalls and are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic, all checked
// against a countdown-based reference model of the stall/flush rules.
module tb_hazard_stall_ctrl;

  localparam int MC = 3;
  localparam int RW = 5;

  logic          clk;
  logic          rst;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] ex_rd;
  logic          ex_memread;
  logic          ex_is_mult;
  logic          mem_branch_tkn;

  logic          pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble, mult_busy;
  logic [15:0]   stall_cnt;
  logic          pc_en4, if_id_en4, id_ex_en4, if_id_flush4, id_ex_bubble4, ex_mem_bubble4;
  logic          mult_busy4;
  logic [3:0]    stall_cnt4;
  logic [6:0]    ctrl;

  int checks = 0;
  int passed = 0;

  // Reference model state: cycles the current multiply still occupies EX, and stall totals.
  int hold_left = 0;
  int cnt16 = 0;
  int cnt4 = 0;

  assign ctrl = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble, mult_busy};

  hazard_stall_ctrl #(.MULT_CYCLES(MC), .REG_ADDR_W(RW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_is_mult(ex_is_mult), .mem_branch_tkn(mem_branch_tkn),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .mult_busy(mult_busy),
    .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.MULT_CYCLES(MC), .REG_ADDR_W(RW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_is_mult(ex_is_mult), .mem_branch_tkn(mem_branch_tkn),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .if_id_flush(if_id_flush4),
    .id_ex_bubble(id_ex_bubble4), .ex_mem_bubble(ex_mem_bubble4), .mult_busy(mult_busy4),
    .stall_cnt(stall_cnt4)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model
  localparam logic [6:0] C_IDLE  = 7'b1110000;
  localparam logic [6:0] C_FLUSH = 7'b1111110;
  localparam logic [6:0] C_MULT  = 7'b0000011;
  localparam logic [6:0] C_LOAD  = 7'b0010100;

  function automatic int eff_hold();
    if (hold_left == 0 && ex_is_mult && MC > 1) return MC;
    return hold_left;
  endfunction

  function automatic logic hazard_load();
    return ex_memread && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [6:0] exp_ctrl();
    int h;
    if (rst) return C_IDLE;
    if (mem_branch_tkn) return C_FLUSH;
    h = eff_hold();
    if (h > 1) return C_MULT;
    if (h == 1) return C_IDLE;
    if (hazard_load()) return C_LOAD;
    return C_IDLE;
  endfunction

  task automatic model_commit();
    logic [6:0] e;
    int h;
    e = exp_ctrl();
    if (rst) begin
      hold_left = 0;
      cnt16 = 0;
      cnt4 = 0;
    end else begin
      if (mem_branch_tkn) begin
        hold_left = 0;
      end else begin
        h = eff_hold();
        hold_left = (h > 0) ? h - 1 : 0;
      end
      if (!e[6]) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_memread = 1'b0; ex_is_mult = 1'b0; mem_branch_tkn = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ex_is_mult = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctrl !== C_IDLE) $display("FAIL reset_outputs cyc%0d got=%b exp=%b", i, ctrl, C_IDLE);
      else passed++;
      tick();
    end
    rst = 1'b0;
    ex_is_mult = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_IDLE || stall_cnt !== 16'd0)
      $display("FAIL after_reset got=%b cnt=%0d exp=%b cnt=0", ctrl, stall_cnt, C_IDLE);
    else passed++;
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_LOAD) $display("FAIL load_use_stall got=%b exp=%b", ctrl, C_LOAD);
    else passed++;
    tick();
    checks++;
    if (stall_cnt !== 16'd1) $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
    else passed++;
    ex_memread = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_IDLE) $display("FAIL load_use_clear got=%b exp=%b", ctrl, C_IDLE);
    else passed++;
    tick();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    checks++;
    if (ctrl !== C_IDLE) $display("FAIL load_use_r0 got=%b exp=%b", ctrl, C_IDLE);
    else passed++;
    tick();
    id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_rs2 = 5'd9; id_use_rs2 = 1'b1; ex_rd = 5'd9;
    #1;
    checks++;
    if (ctrl !== C_LOAD) $display("FAIL load_use_rs2 got=%b exp=%b", ctrl, C_LOAD);
    else passed++;
    tick();
    checks++;
    if (stall_cnt !== 16'd2) $display("FAIL load_use_cnt2 got=%0d exp=2", stall_cnt);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_mult();
    logic [6:0] want;
    int base;
    base = cnt16;
    ex_is_mult = 1'b1;
    ex_memread = 1'b0;
    for (int i = 0; i < MC; i++) begin
      want = (i < MC - 1) ? C_MULT : C_IDLE;
      #1;
      checks++;
      if (ctrl !== want) $display("FAIL mult_cyc%0d got=%b exp=%b", i, ctrl, want);
      else passed++;
      tick();
    end
    ex_is_mult = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_IDLE || stall_cnt !== 16'(base + MC - 1))
      $display("FAIL mult_done got=%b cnt=%0d exp=%b cnt=%0d", ctrl, stall_cnt, C_IDLE, base + MC - 1);
    else passed++;
    tick();
  endtask

  task automatic test_branch_kill();
    ex_is_mult = 1'b1;
    tick();
    mem_branch_tkn = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_FLUSH) $display("FAIL branch_flush got=%b exp=%b", ctrl, C_FLUSH);
    else passed++;
    tick();
    mem_branch_tkn = 1'b0;
    ex_is_mult = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_IDLE) $display("FAIL branch_after got=%b exp=%b", ctrl, C_IDLE);
    else passed++;
    checks++;
    if (stall_cnt !== 16'(cnt16)) $display("FAIL branch_cnt got=%0d exp=%0d", stall_cnt, cnt16);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_mult();
    ex_is_mult = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_IDLE) $display("FAIL rst_mult_out got=%b exp=%b", ctrl, C_IDLE);
    else passed++;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL rst_mult_cnt got=%0d exp=0", stall_cnt);
    else passed++;
    for (int i = 0; i < MC; i++) begin
      #1;
      checks++;
      if (ctrl !== exp_ctrl()) $display("FAIL rst_new_mult cyc%0d got=%b exp=%b", i, ctrl, exp_ctrl());
      else passed++;
      tick();
    end
    ex_is_mult = 1'b0;
    checks++;
    if (stall_cnt !== 16'(MC - 1)) $display("FAIL rst_new_mult_cnt got=%0d exp=%0d", stall_cnt, MC - 1);
    else passed++;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (stall_cnt4 !== 4'(cnt4)) $display("FAIL sat_step%0d got=%0d exp=%0d", i, stall_cnt4, cnt4);
      else passed++;
    end
    checks++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20)
      $display("FAIL sat_final got=%0d/%0d exp=15/20", stall_cnt4, stall_cnt);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      r = $urandom_range(0, 99);
      rst = (r < 2);
      mem_branch_tkn = (r >= 2 && r < 10);
      case ($urandom_range(0, 3))
        0: ex_is_mult = 1'b1;
        1: ex_memread = 1'b1;
        default: ;
      endcase
      ex_rd = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (ctrl !== exp_ctrl()) $display("FAIL rand_ctrl cyc%0d got=%b exp=%b", i, ctrl, exp_ctrl());
      else passed++;
      tick();
      checks++;
      if (stall_cnt !== 16'(cnt16) || stall_cnt4 !== 4'(cnt4))
        $display("FAIL rand_cnt cyc%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, stall_cnt4, cnt16, cnt4);
      else passed++;
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mult();
    test_branch_kill();
    test_reset_mid_mult();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
